// File: rtl/audio_demux_1to5.sv
// 1-to-5 audio sample demultiplexer with a one-entry registered output buffer.
// Select changes drain the current path and wait a settle gap before re-routing.
module audio_demux_1to5 #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [4:0]       m_valid,
   input  logic [4:0]       m_ready,
   output logic [2:0]       active_sel,
   output logic             switching
);

   localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_SETTLE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       active_q, active_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic [4:0]       m_valid_q, m_valid_d;
   logic             switching_q;
   logic [2:0]       tsel;
   logic             buf_v;
   logic             sink_rdy;
   logic             out_fire;

   always_comb begin
      tsel     = (sel > 3'd4) ? 3'd0 : sel;
      buf_v    = |m_valid_q;
      sink_rdy = m_ready[active_q];
      out_fire = buf_v & sink_rdy;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      s_ready   = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            s_ready = (tsel == active_q) & (~buf_v | sink_rdy);
            if (tsel != active_q) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // A delivery in this very cycle already empties the buffer.
            if (~buf_v | out_fire) begin
               if (SETTLE == 0) begin
                  active_d = tsel;
                  state_d  = ST_RUN;
               end else begin
                  cnt_d   = CW'(SETTLE);
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
            if (cnt_q <= CW'(1)) begin
               active_d = tsel;
               state_d  = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (s_valid & s_ready) begin
         m_data_d  = s_data;
         m_valid_d = 5'(1) << active_q;
      end else if (out_fire) begin
         m_valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         active_q    <= '0;
         m_data_q    <= '0;
         m_valid_q   <= '0;
         switching_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         switching_q <= (state_d != ST_RUN);
      end
   end

   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign active_sel = active_q;
   assign switching  = switching_q;

endmodule

// File: tb/tb_audio_demux_1to5.sv
// Directed bench for audio_demux_1to5: SETTLE=4 main instance plus a SETTLE=0 build.
module tb_audio_demux_1to5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] sel, sel0;
   logic [7:0] s_data;
   logic       s_valid;
   logic [4:0] m_ready;

   logic       s_ready, switching;
   logic [7:0] m_data;
   logic [4:0] m_valid;
   logic [2:0] active_sel;

   logic       s_ready0, switching0;
   logic [7:0] m_data0;
   logic [4:0] m_valid0;
   logic [2:0] active_sel0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   audio_demux_1to5 #(.WIDTH(8), .SETTLE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .active_sel(active_sel), .switching(switching)
   );

   audio_demux_1to5 #(.WIDTH(8), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sel(sel0), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
      .active_sel(active_sel0), .switching(switching0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; sel = 3'd0; sel0 = 3'd0; s_valid = 1'b0; s_data = 8'h00; m_ready = 5'h00;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (m_valid !== 5'b00000) begin failures++; $display("FAIL rst_m_valid got=%b exp=%b", m_valid, 5'b00000); end
      checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%h exp=%h", m_data, 8'h00); end
      checks++; if (active_sel !== 3'd0) begin failures++; $display("FAIL rst_active got=%0d exp=0", active_sel); end
      checks++; if (switching !== 1'b0) begin failures++; $display("FAIL rst_switching got=%b exp=0", switching); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_streaming;
      m_ready = 5'h1f; sel = 3'd0; s_valid = 1'b1; s_data = 8'h11;
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_rdy0 got=%b exp=1", s_ready); end
      tick; s_data = 8'h22; #1;
      checks++; if (m_valid !== 5'b00001 || m_data !== 8'h11) begin failures++; $display("FAIL stream_s1 got=%b/%h exp=00001/11", m_valid, m_data); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_rdy1 got=%b exp=1", s_ready); end
      tick; s_data = 8'h33; #1;
      checks++; if (m_valid !== 5'b00001 || m_data !== 8'h22) begin failures++; $display("FAIL stream_s2 got=%b/%h exp=00001/22", m_valid, m_data); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_rdy2 got=%b exp=1", s_ready); end
      tick; s_valid = 1'b0; #1;
      checks++; if (m_valid !== 5'b00001 || m_data !== 8'h33) begin failures++; $display("FAIL stream_s3 got=%b/%h exp=00001/33", m_valid, m_data); end
      tick;
      checks++; if (m_valid !== 5'b00000 || m_data !== 8'h33) begin failures++; $display("FAIL stream_empty got=%b/%h exp=00000/33", m_valid, m_data); end
   endtask

   task automatic test_backpressure;
      int n;
      sel = 3'd2; n = 0;
      while (active_sel !== 3'd2 && n < 20) begin tick; n++; end
      checks++; if (active_sel !== 3'd2) begin failures++; $display("FAIL bp_switch got=%0d exp=2", active_sel); end
      m_ready = 5'b11011; s_valid = 1'b1; s_data = 8'hA5;
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_empty got=%b exp=1", s_ready); end
      tick; s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (m_valid !== 5'b00100 || m_data !== 8'hA5) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=00100/a5", i, m_valid, m_data); end
         checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy_full%0d got=%b exp=0", i, s_ready); end
         tick;
      end
      m_ready = 5'h1f; #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_release got=%b exp=1", s_ready); end
      tick;
      checks++; if (m_valid !== 5'b00000) begin failures++; $display("FAIL bp_consumed got=%b exp=00000", m_valid); end
   endtask

   task automatic test_switch_pending;
      int n;
      sel = 3'd1; n = 0;
      while (active_sel !== 3'd1 && n < 20) begin tick; n++; end
      checks++; if (active_sel !== 3'd1) begin failures++; $display("FAIL sw_pre got=%0d exp=1", active_sel); end
      m_ready = 5'b11101; s_valid = 1'b1; s_data = 8'h5C;
      tick;
      sel = 3'd3; s_data = 8'h7E; #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL sw_rdy_selchg got=%b exp=0", s_ready); end
      tick;
      checks++; if (switching !== 1'b1) begin failures++; $display("FAIL sw_switching got=%b exp=1", switching); end
      checks++; if (m_valid !== 5'b00010 || m_data !== 8'h5C) begin failures++; $display("FAIL sw_held got=%b/%h exp=00010/5c", m_valid, m_data); end
      tick;
      checks++; if (m_valid !== 5'b00010 || m_data !== 8'h5C || s_ready !== 1'b0) begin failures++; $display("FAIL sw_drain got=%b/%h rdy=%b exp=00010/5c rdy=0", m_valid, m_data, s_ready); end
      m_ready = 5'h1f;
      tick;
      for (int i = 0; i < 4; i++) begin
         checks++; if (m_valid !== 5'b00000 || active_sel !== 3'd1 || s_ready !== 1'b0) begin failures++; $display("FAIL sw_gap%0d got=%b/%0d rdy=%b exp=00000/1 rdy=0", i, m_valid, active_sel, s_ready); end
         tick;
      end
      #1;
      checks++; if (active_sel !== 3'd3 || s_ready !== 1'b1) begin failures++; $display("FAIL sw_active got=%0d rdy=%b exp=3 rdy=1", active_sel, s_ready); end
      tick; s_valid = 1'b0;
      checks++; if (m_valid !== 5'b01000 || m_data !== 8'h7E) begin failures++; $display("FAIL sw_newsample got=%b/%h exp=01000/7e", m_valid, m_data); end
      tick;
      checks++; if (switching !== 1'b0 || m_valid !== 5'b00000) begin failures++; $display("FAIL sw_done got=%b/%b exp=0/00000", switching, m_valid); end
   endtask

   task automatic test_invalid_late;
      int n;
      s_valid = 1'b0; sel = 3'd6; n = 0;
      while (active_sel !== 3'd0 && n < 20) begin tick; n++; end
      #1;
      checks++; if (active_sel !== 3'd0 || s_ready !== 1'b1) begin failures++; $display("FAIL inv_map got=%0d rdy=%b exp=0 rdy=1", active_sel, s_ready); end
      sel = 3'd4; #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL late_rdy got=%b exp=0", s_ready); end
      tick;
      checks++; if (switching !== 1'b1) begin failures++; $display("FAIL late_switching got=%b exp=1", switching); end
      tick;
      sel = 3'd0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (m_valid !== 5'b00000 || active_sel !== 3'd0 || switching !== 1'b1) begin failures++; $display("FAIL late_gap%0d got=%b/%0d/%b exp=00000/0/1", i, m_valid, active_sel, switching); end
      end
      tick; #1;
      checks++; if (active_sel !== 3'd0 || s_ready !== 1'b1) begin failures++; $display("FAIL late_resume got=%0d rdy=%b exp=0 rdy=1", active_sel, s_ready); end
      s_valid = 1'b1; s_data = 8'h44;
      tick; s_valid = 1'b0;
      checks++; if (m_valid !== 5'b00001 || m_data !== 8'h44) begin failures++; $display("FAIL late_stream got=%b/%h exp=00001/44", m_valid, m_data); end
      tick;
   endtask

   task automatic test_reset_mid;
      int n;
      m_ready = 5'h1f; sel = 3'd2; n = 0;
      while (active_sel !== 3'd2 && n < 20) begin tick; n++; end
      checks++; if (active_sel !== 3'd2) begin failures++; $display("FAIL rm_pre got=%0d exp=2", active_sel); end
      m_ready = 5'b11011; s_valid = 1'b1; s_data = 8'h99;
      tick; s_valid = 1'b0;
      checks++; if (m_valid !== 5'b00100) begin failures++; $display("FAIL rm_buffered got=%b exp=00100", m_valid); end
      sel = 3'd4;
      tick;
      checks++; if (switching !== 1'b1) begin failures++; $display("FAIL rm_switching got=%b exp=1", switching); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 5'b00000 || active_sel !== 3'd0 || m_data !== 8'h00) begin failures++; $display("FAIL rm_async got=%b/%0d/%h exp=00000/0/00", m_valid, active_sel, m_data); end
      checks++; if (switching !== 1'b0) begin failures++; $display("FAIL rm_async_sw got=%b exp=0", switching); end
      tick;
      m_ready = 5'h1f; sel = 3'd0; rst_n = 1'b1;
      tick;
      s_valid = 1'b1; s_data = 8'h01; #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rm_rdy got=%b exp=1", s_ready); end
      tick; s_valid = 1'b0;
      checks++; if (m_valid !== 5'b00001 || m_data !== 8'h01) begin failures++; $display("FAIL rm_deliver got=%b/%h exp=00001/01", m_valid, m_data); end
   endtask

   task automatic test_settle0;
      s_valid = 1'b0;
      tick;
      sel0 = 3'd1; #1;
      checks++; if (s_ready0 !== 1'b0) begin failures++; $display("FAIL s0_rdy got=%b exp=0", s_ready0); end
      tick;
      checks++; if (switching0 !== 1'b1 || active_sel0 !== 3'd0) begin failures++; $display("FAIL s0_drain got=%b/%0d exp=1/0", switching0, active_sel0); end
      tick; #1;
      checks++; if (active_sel0 !== 3'd1 || switching0 !== 1'b0 || s_ready0 !== 1'b1) begin failures++; $display("FAIL s0_run got=%0d/%b rdy=%b exp=1/0 rdy=1", active_sel0, switching0, s_ready0); end
      s_valid = 1'b1; s_data = 8'h3C;
      tick; s_valid = 1'b0;
      checks++; if (m_valid0 !== 5'b00010 || m_data0 !== 8'h3C) begin failures++; $display("FAIL s0_sample got=%b/%h exp=00010/3c", m_valid0, m_data0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_streaming;
      test_backpressure;
      test_switch_pending;
      test_invalid_late;
      test_reset_mid;
      test_settle0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
